// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and helpers for the I2S receive-side decimator
//
// Purpose: FSM state encoding, the default largest decimation exponent and the
// exponent clamp used when a block's configuration is latched.
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam int DEC_MAX_LOG2 = 5;

   // Exponents above the supported maximum are treated as the maximum.
   function automatic logic [2:0] clamp_log2(input logic [2:0] d, input logic [2:0] max_log2);
      return (d > max_log2) ? max_log2 : d;
   endfunction

endpackage

// File: rtl/i2s_pcm_decimator.sv
// rtl/i2s_pcm_decimator.sv - block-average decimator between the I2S sample FIFO and the bus side
//
// Purpose: pops samples from a first-word-fall-through FIFO, sums blocks of
// 2^dec_log2 samples and presents the rounded mean on a valid/ready stream.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   en                 run enable, honoured at block boundaries
//   clr                synchronous flush of accumulator, counter and output
//   dec_log2           block size exponent, clamped to MAX_LOG2
//   is_signed          1 = two's-complement samples, 0 = unsigned
//   fifo_empty         FIFO has no word at its head
//   fifo_rdata         FIFO head word (valid while fifo_empty=0)
//   fifo_rd            pop strobe, one word per asserted cycle
//   m_valid, m_ready   output stream handshake
//   m_data             block mean
//   busy               block partially accumulated or output pending
module i2s_pcm_decimator
   import i2s_pkg::*;
#(
   parameter int DW       = 32,
   parameter int MAX_LOG2 = DEC_MAX_LOG2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [2:0]    dec_log2,
   input  logic          is_signed,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_rdata,
   output logic          fifo_rd,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          busy
);

   // Accumulator carries MAX_LOG2 guard bits so a full block of extreme
   // samples plus the rounding bias never overflows.
   localparam int         AW    = DW + MAX_LOG2;
   localparam int         CW    = MAX_LOG2 + 1;
   localparam logic [2:0] MAX_L = 3'(MAX_LOG2);

   state_t          state;
   state_t          state_n;
   logic [AW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   last_cnt;
   logic [2:0]      dsh;
   logic            sgn;
   logic [AW-1:0]   sample_ext;
   logic [AW-1:0]   sum;
   logic [AW-1:0]   biased;
   logic [AW-1:0]   rounded;
   logic            latch;
   logic            finish;

   assign sample_ext = sgn ? {{MAX_LOG2{fifo_rdata[DW-1]}}, fifo_rdata}
                           : {{MAX_LOG2{1'b0}}, fifo_rdata};
   assign sum        = acc + sample_ext;
   assign last_cnt   = (CW'(1) << dsh) - CW'(1);
   assign busy       = ((state == COLLECT) && (cnt != '0)) || m_valid;

   // Round half up, then divide; the shift is arithmetic for signed blocks so
   // negative means floor correctly after the bias is added.
   always_comb begin
      biased  = sum;
      rounded = sum;
      if (dsh != 3'd0) begin
         biased  = sum + (AW'(1) << (dsh - 3'd1));
         rounded = sgn ? AW'($signed(biased) >>> dsh) : (biased >> dsh);
      end
   end

   always_comb begin
      state_n = state;
      fifo_rd = 1'b0;
      latch   = 1'b0;
      finish  = 1'b0;
      if (clr) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state_n = COLLECT;
                  latch   = 1'b1;
               end
            end
            COLLECT: begin
               // Stopping is only allowed on a block boundary; a started
               // block always runs to completion.
               if (!en && (cnt == '0)) begin
                  state_n = IDLE;
               end else if (!fifo_empty) begin
                  fifo_rd = 1'b1;
                  if (cnt == last_cnt) begin
                     finish  = 1'b1;
                     state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               if (m_valid && m_ready) begin
                  state_n = en ? COLLECT : IDLE;
                  latch   = en;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         dsh     <= '0;
         sgn     <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         if (latch) begin
            dsh <= clamp_log2(dec_log2, MAX_L);
            sgn <= is_signed;
         end
         if (fifo_rd) begin
            if (finish) begin
               m_data  <= rounded[DW-1:0];
               m_valid <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CW'(1);
            end
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule
